pll_supervisor: RTL

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

---
 rtl/pll_supervisor_pkg.sv | 34 +++
 rtl/hb_edge_sync.sv | 25 ++
 rtl/pll_supervisor.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pll_supervisor_pkg.sv
// Shared FSM state type, default timing constants and small helpers
// for the PLL lock supervisor.
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_RUN     = 3'd3,
        ST_FAULT   = 3'd4
    } sup_state_t;

    localparam int DEF_RST_HOLD_CYC = 64;
    localparam int DEF_SETTLE_CYC   = 5000;
    localparam int DEF_WIN_CYC      = 1024;
    localparam int DEF_HB_MIN       = 60;
    localparam int DEF_HB_MAX       = 68;
    localparam int DEF_MAX_RETRY    = 3;

    localparam int EDGE_CNT_W = 8;
    localparam int RETRY_W    = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [EDGE_CNT_W-1:0] sat_add(input logic [EDGE_CNT_W-1:0] cnt,
                                                      input logic                  inc);
        return (inc && (cnt != '1)) ? cnt + EDGE_CNT_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/hb_edge_sync.sv
// Brings the asynchronous heartbeat into the refclk domain and flags
// every transition (rising and falling) as a single-cycle pulse.
module hb_edge_sync
    import pll_supervisor_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_hb,
    output logic o_edge
);

    // [0],[1] form the synchronizer; [2] is the delayed copy for edge detect
    logic [2:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], i_hb};
        end
    end

    assign o_edge = r_sync[1] ^ r_sync[2];

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset sequencer and lock checker: holds the PLL in reset, lets it
// settle, then counts heartbeat edges per window to qualify the output clock.
//
// state   | meaning
// HOLD    | pll_rst asserted for RST_HOLD_CYC cycles
// SETTLE  | pll_rst released, heartbeat ignored for SETTLE_CYC cycles
// MEASURE | first qualification window
// RUN     | clock verified, windows repeat back-to-back
// FAULT   | retries exhausted, PLL kept in reset until reset
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int RST_HOLD_CYC = DEF_RST_HOLD_CYC,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int WIN_CYC      = DEF_WIN_CYC,
    parameter int HB_MIN       = DEF_HB_MIN,
    parameter int HB_MAX       = DEF_HB_MAX,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic                  refclk,
    input  logic                  reset,
    input  logic                  hb_in,
    output logic                  pll_rst,
    output logic                  clk_ok,
    output logic                  fault,
    output logic [RETRY_W-1:0]    retry_cnt,
    output logic [EDGE_CNT_W-1:0] last_count
);

    localparam int TMR_W = $clog2(max3(RST_HOLD_CYC, SETTLE_CYC, WIN_CYC) + 1);

    localparam logic [TMR_W-1:0]      HOLD_LOAD   = TMR_W'(RST_HOLD_CYC - 1);
    localparam logic [TMR_W-1:0]      HOLD_FIRST  = TMR_W'((RST_HOLD_CYC > 1) ? RST_HOLD_CYC - 2 : 0);
    localparam logic [TMR_W-1:0]      SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]      WIN_LOAD    = TMR_W'(WIN_CYC - 1);
    localparam logic [RETRY_W-1:0]    RETRY_LIM   = RETRY_W'(MAX_RETRY);
    localparam logic [EDGE_CNT_W-1:0] CNT_MIN     = EDGE_CNT_W'(HB_MIN);
    localparam logic [EDGE_CNT_W-1:0] CNT_MAX     = EDGE_CNT_W'(HB_MAX);

    sup_state_t            r_state;
    logic [TMR_W-1:0]      r_tmr;
    logic                  r_tmr_fresh;
    logic [EDGE_CNT_W-1:0] r_edge_cnt;

    logic                  w_edge;
    logic                  w_tmr_done;
    logic [EDGE_CNT_W-1:0] w_final_cnt;
    logic                  w_in_range;
    logic [RETRY_W-1:0]    w_retry_nxt;

    hb_edge_sync u_hb_edge_sync (
        .i_clk   (refclk),
        .i_reset (reset),
        .i_hb    (hb_in),
        .o_edge  (w_edge)
    );

    assign w_tmr_done  = (r_tmr == '0);
    assign w_final_cnt = sat_add(r_edge_cnt, w_edge);
    assign w_in_range  = (w_final_cnt >= CNT_MIN) && (w_final_cnt <= CNT_MAX);
    assign w_retry_nxt = (retry_cnt >= RETRY_LIM) ? retry_cnt : retry_cnt + RETRY_W'(1);

    always_ff @(posedge refclk) begin
        if (reset) begin
            r_state     <= ST_HOLD;
            r_tmr       <= '0;
            r_tmr_fresh <= 1'b1;
            r_edge_cnt  <= '0;
            pll_rst     <= 1'b1;
            clk_ok      <= 1'b0;
            fault       <= 1'b0;
            retry_cnt   <= '0;
            last_count  <= '0;
        end else begin
            r_tmr_fresh <= 1'b0;
            unique case (r_state)
                ST_HOLD: begin
                    // Reset leaves the timer at zero, so the first HOLD cycle
                    // after reset loads it with that cycle already spent.
                    if (r_tmr_fresh && (RST_HOLD_CYC > 1)) begin
                        r_tmr <= HOLD_FIRST;
                    end else if (w_tmr_done) begin
                        r_state <= ST_SETTLE;
                        r_tmr   <= SETTLE_LOAD;
                        pll_rst <= 1'b0;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end

                ST_SETTLE: begin
                    if (w_tmr_done) begin
                        r_state    <= ST_MEASURE;
                        r_tmr      <= WIN_LOAD;
                        r_edge_cnt <= '0;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end

                ST_MEASURE, ST_RUN: begin
                    if (w_tmr_done) begin
                        last_count <= w_final_cnt;
                        r_edge_cnt <= '0;
                        r_tmr      <= WIN_LOAD;
                        if (w_in_range) begin
                            r_state <= ST_RUN;
                            clk_ok  <= 1'b1;
                        end else begin
                            retry_cnt <= w_retry_nxt;
                            clk_ok    <= 1'b0;
                            pll_rst   <= 1'b1;
                            if (w_retry_nxt == RETRY_LIM) begin
                                r_state <= ST_FAULT;
                                fault   <= 1'b1;
                            end else begin
                                r_state <= ST_HOLD;
                                r_tmr   <= HOLD_LOAD;
                            end
                        end
                    end else begin
                        r_tmr      <= r_tmr - TMR_W'(1);
                        r_edge_cnt <= w_final_cnt;
                    end
                end

                ST_FAULT: begin
                    pll_rst <= 1'b1;
                    clk_ok  <= 1'b0;
                    fault   <= 1'b1;
                end

                default: begin
                    r_state <= ST_FAULT;
                    pll_rst <= 1'b1;
                    clk_ok  <= 1'b0;
                    fault   <= 1'b1;
                end
            endcase
        end
    end

endmodule
